// File: rtl/dseq_pkg.sv
// dseq_pkg: shared state encoding, ALU opcodes and fixed addresses for the distance sequencer.
package dseq_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD_A,
    S_LOAD_B,
    S_ABS,
    S_ACC,
    S_OUT
  } state_t;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_SUB     = 2'b01;
  localparam logic [1:0] OP_ABSDIFF = 2'b10;
  localparam logic [1:0] OP_PASS    = 2'b11;
  localparam int ACC_ADDR = 0;
endpackage

// File: rtl/dseq_decode.sv
// dseq_decode: combinational map from sequencer state, element index and stream valid to datapath controls.
module dseq_decode
  import dseq_pkg::*;
#(
  parameter int W = 4
) (
  input  state_t         state,
  input  logic [W-1:0]   k,
  input  logic           In_valid,
  output logic           In_ready,
  output logic           Busy,
  output logic           Done,
  output logic           Write_en,
  output logic           Mux_in,
  output logic [W-1:0]   Addr_in,
  output logic [1:0]     Opcode,
  output logic [W-1:0]   Addr_out1,
  output logic [W-1:0]   Addr_out2,
  output logic           Out_enable
);
  localparam logic [W-1:0] HALF = W'(1 << (W - 1));
  localparam logic [W-1:0] ACC  = W'(ACC_ADDR);
  always_comb begin
    In_ready   = 1'b0;
    Busy       = state != S_IDLE;
    Done       = 1'b0;
    Write_en   = 1'b0;
    Mux_in     = 1'b0;
    Addr_in    = '0;
    Opcode     = OP_ADD;
    Addr_out1  = '0;
    Addr_out2  = '0;
    Out_enable = 1'b0;
    case (state)
      S_CLEAR: begin
        Opcode    = OP_SUB;
        Addr_out1 = ACC;
        Addr_out2 = ACC;
        Addr_in   = ACC;
        Mux_in    = 1'b1;
        Write_en  = 1'b1;
      end
      S_LOAD_A: begin
        In_ready = 1'b1;
        Addr_in  = k;
        Write_en = In_valid;
      end
      S_LOAD_B: begin
        In_ready = 1'b1;
        Addr_in  = HALF + k;
        Write_en = In_valid;
      end
      S_ABS: begin
        Opcode    = OP_ABSDIFF;
        Addr_out1 = k;
        Addr_out2 = HALF + k;
        Addr_in   = HALF;
        Mux_in    = 1'b1;
        Write_en  = 1'b1;
      end
      S_ACC: begin
        Opcode    = OP_ADD;
        Addr_out1 = ACC;
        Addr_out2 = HALF;
        Addr_in   = ACC;
        Mux_in    = 1'b1;
        Write_en  = 1'b1;
      end
      S_OUT: begin
        Addr_out1  = ACC;
        Out_enable = 1'b1;
        Done       = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/distance_sequencer.sv
// distance_sequencer: start/busy/done FSM that loads two vectors and accumulates their Manhattan distance.
// Optional DSEQ_ABORT_EN adds an Abort input that returns any running sequence to IDLE.
module distance_sequencer
  import dseq_pkg::*;
#(
  parameter int num_bit_of_column = 4
) (
  input  logic                         CLK,
  input  logic                         RST_n,
`ifdef DSEQ_ABORT_EN
  input  logic                         Abort,
`endif
  input  logic                         Start,
  input  logic [num_bit_of_column-1:0] Length,
  input  logic                         In_valid,
  output logic                         In_ready,
  output logic                         Busy,
  output logic                         Done,
  output logic                         Write_en,
  output logic                         Mux_in,
  output logic [num_bit_of_column-1:0] Addr_in,
  output logic [1:0]                   Opcode,
  output logic [num_bit_of_column-1:0] Addr_out1,
  output logic [num_bit_of_column-1:0] Addr_out2,
  output logic                         Out_enable
);
  localparam int W = num_bit_of_column;
  localparam logic [W-1:0] LMAX = W'((1 << (W - 1)) - 1);
  state_t state, state_n;
  logic [W-1:0] k, k_n, l, l_n;
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state <= S_IDLE;
      k     <= '0;
      l     <= '0;
    end else begin
      state <= state_n;
      k     <= k_n;
      l     <= l_n;
    end
  end
  always_comb begin
    state_n = state;
    k_n     = k;
    l_n     = l;
    case (state)
      S_IDLE: if (Start) begin
        state_n = S_CLEAR;
        l_n     = Length > LMAX ? LMAX : Length;
        k_n     = W'(1);
      end
      S_CLEAR: state_n = l != '0 ? S_LOAD_A : S_OUT;
      S_LOAD_A: if (In_valid) begin
        state_n = k == l ? S_LOAD_B : S_LOAD_A;
        k_n     = k == l ? W'(1) : k + W'(1);
      end
      S_LOAD_B: if (In_valid) begin
        state_n = k == l ? S_ABS : S_LOAD_B;
        k_n     = k == l ? W'(1) : k + W'(1);
      end
      S_ABS: state_n = S_ACC;
      S_ACC: begin
        state_n = k < l ? S_ABS : S_OUT;
        k_n     = k + W'(1);
      end
      S_OUT: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
`ifdef DSEQ_ABORT_EN
    // Abort also masks a Start arriving in IDLE.
    if (Abort) begin
      state_n = S_IDLE;
      k_n     = k;
      l_n     = l;
    end
`endif
  end
  dseq_decode #(.W(W)) u_decode (
    .state      (state),
    .k          (k),
    .In_valid   (In_valid),
    .In_ready   (In_ready),
    .Busy       (Busy),
    .Done       (Done),
    .Write_en   (Write_en),
    .Mux_in     (Mux_in),
    .Addr_in    (Addr_in),
    .Opcode     (Opcode),
    .Addr_out1  (Addr_out1),
    .Addr_out2  (Addr_out2),
    .Out_enable (Out_enable)
  );
endmodule

// File: tb/tb_distance_sequencer.sv
// tb_distance_sequencer: scoreboard bench driving directed runs through a small behavioural datapath.
module tb_distance_sequencer;
  import dseq_pkg::*;
  localparam int W = 4;
  typedef int vec_t[7];
  typedef struct {
    bit         done;
    logic [3:0] addr;
    logic       mux;
    bit         rd;
    logic [3:0] r1;
    logic [3:0] r2;
    logic [1:0] op;
    int         val;
    int         lat;
  } ev_t;
  logic CLK = 1'b0;
  logic RST_n = 1'b0;
  logic Start = 1'b0;
  logic In_valid = 1'b0;
  logic [W-1:0] Length = '0;
  logic [7:0] in_data = '0;
`ifdef DSEQ_ABORT_EN
  logic Abort = 1'b0;
`endif
  logic In_ready, Busy, Done, Write_en, Mux_in, Out_enable;
  logic [W-1:0] Addr_in, Addr_out1, Addr_out2;
  logic [1:0] Opcode;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  bit mon_en = 1'b1;
  ev_t q[$];
  ev_t e;
  always #5 CLK = ~CLK;
  distance_sequencer #(.num_bit_of_column(W)) dut (
    .CLK        (CLK),
    .RST_n      (RST_n),
`ifdef DSEQ_ABORT_EN
    .Abort      (Abort),
`endif
    .Start      (Start),
    .Length     (Length),
    .In_valid   (In_valid),
    .In_ready   (In_ready),
    .Busy       (Busy),
    .Done       (Done),
    .Write_en   (Write_en),
    .Mux_in     (Mux_in),
    .Addr_in    (Addr_in),
    .Opcode     (Opcode),
    .Addr_out1  (Addr_out1),
    .Addr_out2  (Addr_out2),
    .Out_enable (Out_enable)
  );
  // Register file + ALU environment so the accumulated distance can be checked.
  logic [7:0] rf [16];
  logic [7:0] ra, rb, alu, out_reg;
  assign ra = rf[Addr_out1];
  assign rb = rf[Addr_out2];
  always_comb begin
    alu = ra;
    case (Opcode)
      2'b00: alu = ra + rb;
      2'b01: alu = ra - rb;
      2'b10: alu = ra > rb ? ra - rb : rb - ra;
      default: alu = ra;
    endcase
  end
  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (Write_en) rf[Addr_in] <= Mux_in ? alu : in_data;
    if (Out_enable) out_reg <= ra;
  end
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  function automatic int outs_all();
    return int'({In_ready, Busy, Done, Write_en, Mux_in, Addr_in, Opcode, Addr_out1, Addr_out2, Out_enable});
  endfunction
  always begin
    @(negedge CLK);
    #2;
    if (RST_n && mon_en && (Write_en || Done)) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: got write=%0d done=%0d expected none", Write_en, Done);
      end else begin
        e = q.pop_front();
        chk("event_kind", int'(Done), int'(e.done));
        if (e.done) begin
          chk("done_latency", cyc + 1 - start_cyc, e.lat);
          chk("result", int'(ra), e.val);
          chk("out_enable", int'(Out_enable), 1);
          chk("busy_in_out", int'(Busy), 1);
        end else begin
          chk("write_addr", int'(Addr_in), int'(e.addr));
          chk("mux_in", int'(Mux_in), int'(e.mux));
          if (e.rd) begin
            chk("rd_addr1", int'(Addr_out1), int'(e.r1));
            chk("rd_addr2", int'(Addr_out2), int'(e.r2));
            chk("opcode", int'(Opcode), int'(e.op));
          end
        end
      end
    end
  end
  task automatic push_w(input int addr, input bit mux, input bit rd, input int r1, input int r2, input logic [1:0] op);
    ev_t x;
    x.done = 1'b0;
    x.addr = 4'(addr);
    x.mux  = mux;
    x.rd   = rd;
    x.r1   = 4'(r1);
    x.r2   = 4'(r2);
    x.op   = op;
    x.val  = 0;
    x.lat  = 0;
    q.push_back(x);
  endtask
  task automatic push_run(input int n, input int val, input int lat);
    ev_t x;
    push_w(0, 1'b1, 1'b1, 0, 0, OP_SUB);
    for (int i = 1; i <= n; i++) push_w(i, 1'b0, 1'b0, 0, 0, OP_ADD);
    for (int i = 1; i <= n; i++) push_w(8 + i, 1'b0, 1'b0, 0, 0, OP_ADD);
    for (int i = 1; i <= n; i++) begin
      push_w(8, 1'b1, 1'b1, i, 8 + i, OP_ABSDIFF);
      push_w(0, 1'b1, 1'b1, 0, 8, OP_ADD);
    end
    x = '{done: 1'b1, addr: 4'd0, mux: 1'b0, rd: 1'b0, r1: 4'd0, r2: 4'd0, op: 2'd0, val: val, lat: lat};
    q.push_back(x);
  endtask
  task automatic start(input int len);
    Start = 1'b1;
    Length = W'(len);
    start_cyc = cyc + 1;
    @(negedge CLK);
    Start = 1'b0;
  endtask
  task automatic feed(input int v, input int stall);
    int g = 0;
    In_valid = 1'b0;
    repeat (stall) @(negedge CLK);
    while (!In_ready && g < 20) begin
      @(negedge CLK);
      g++;
    end
    if (!In_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end
    In_valid = 1'b1;
    in_data = 8'(v);
    @(negedge CLK);
    In_valid = 1'b0;
  endtask
  task automatic wait_done();
    int g = 0;
    while (!Done && g < 100) begin
      @(negedge CLK);
      g++;
    end
    if (!Done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no Done expected Done within 100 cycles");
      q.delete();
    end
    @(negedge CLK);
  endtask
  task automatic run(input int len, input int n, input vec_t a, input vec_t b, input int stall_beat,
                     input int stall_n, input bit pulse, input int val, input int lat);
    push_run(n, val, lat);
    start(len);
    for (int i = 0; i < n; i++) feed(a[i], i == stall_beat ? stall_n : 0);
    for (int i = 0; i < n; i++) feed(b[i], 0);
    if (pulse) begin
      Start = 1'b1;
      @(negedge CLK);
      Start = 1'b0;
    end
    wait_done();
  endtask
  initial begin
    #1;
    chk("reset_outputs", outs_all(), 0);
    @(negedge CLK);
    @(negedge CLK);
    RST_n = 1'b1;
    @(negedge CLK);
    chk("idle_outputs", outs_all(), 0);
    run(3, 3, '{5, 2, 9, 0, 0, 0, 0}, '{1, 7, 9, 0, 0, 0, 0}, -1, 0, 1'b0, 9, 14);
    run(3, 3, '{5, 2, 9, 0, 0, 0, 0}, '{1, 7, 9, 0, 0, 0, 0}, 1, 2, 1'b0, 9, 16);
    run(0, 0, '{0, 0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0}, -1, 0, 1'b0, 0, 2);
    run(12, 7, '{1, 2, 3, 4, 5, 6, 7}, '{7, 6, 5, 4, 3, 2, 1}, -1, 0, 1'b0, 24, 30);
    run(1, 1, '{20, 0, 0, 0, 0, 0, 0}, '{50, 0, 0, 0, 0, 0, 0}, -1, 0, 1'b1, 30, 6);
    run(2, 2, '{3, 10, 0, 0, 0, 0, 0}, '{8, 4, 0, 0, 0, 0, 0}, -1, 0, 1'b0, 11, 10);
    mon_en = 1'b0;
    start(2);
    feed(3, 0);
    In_valid = 1'b1;
    in_data = 8'd77;
    #1;
    chk("pre_reset_write_en", int'(Write_en), 1);
    RST_n = 1'b0;
    #1;
    chk("mid_load_reset_outputs", outs_all(), 0);
    @(negedge CLK);
    In_valid = 1'b0;
    RST_n = 1'b1;
    @(negedge CLK);
    mon_en = 1'b1;
    run(2, 2, '{3, 10, 0, 0, 0, 0, 0}, '{8, 4, 0, 0, 0, 0, 0}, -1, 0, 1'b0, 11, 10);
`ifdef DSEQ_ABORT_EN
    begin
      bit seen = 1'b0;
      mon_en = 1'b0;
      start(1);
      feed(20, 0);
      feed(50, 0);
      @(negedge CLK);
      chk("in_acc_opcode", int'(Opcode), int'(OP_ADD));
      Abort = 1'b1;
      @(negedge CLK);
      Abort = 1'b0;
      chk("abort_busy", int'(Busy), 0);
      chk("abort_outputs", outs_all(), 0);
      repeat (6) begin
        @(negedge CLK);
        seen |= Done;
      end
      chk("abort_no_done", int'(seen), 0);
      Abort = 1'b1;
      Start = 1'b1;
      Length = W'(2);
      @(negedge CLK);
      Abort = 1'b0;
      Start = 1'b0;
      chk("abort_start_idle", int'(Busy), 0);
      mon_en = 1'b1;
    end
`endif
    chk("queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/distance_sequencer.md
# distance_sequencer

Handshake-driven controller that sequences the register-file/ALU distance datapath. It replaces the free-running state counter with a start/busy/done FSM and runs three phases: it loads two vectors of programmable length from an input stream, accumulates the Manhattan distance Σ|A[k]−B[k]| using the ALU, then strobes the result out. It sits between the top-level host interface and the datapath and drives every datapath control line.

## Interface
- num_bit_of_column, 4, register-file address width; HALF = 2^(num_bit_of_column−1)
- CLK  in  1  clock, rising edge
- RST_n  in  1  asynchronous, active-low reset
- Start  in  1  request; sampled only in IDLE
- Length  in  num_bit_of_column  element count; latched on Start
- In_valid  in  1  input stream beat valid
- In_ready  out  1  sequencer accepts a beat (LOAD phases)
- Busy  out  1  high in every state except IDLE
- Done  out  1  one-cycle pulse in OUT
- Write_en  out  1  register-file write strobe
- Mux_in  out  1  write-data select: 0 = stream, 1 = ALU result
- Addr_in  out  num_bit_of_column  write address
- Opcode  out  2  ALU op: 00 ADD, 01 SUB, 10 ABSDIFF, 11 PASS
- Addr_out1, Addr_out2  out  num_bit_of_column  read addresses
- Out_enable  out  1  load the output register from read port 1

## Operation
- Memory map: address 0 = accumulator, A[k] at k (1..HALF−1), HALF = temp, B[k] at HALF+k.
- L = min(Length, HALF−1), latched on Start.
- States: IDLE → CLEAR → LOAD_A → LOAD_B → ABS ↔ ACC → OUT → IDLE.
- IDLE: all outputs 0. Start=1 → CLEAR.
- CLEAR: Opcode SUB, Addr_out1 = Addr_out2 = 0, Addr_in 0, Mux_in 1, Write_en 1. This writes acc = 0. Next state: LOAD_A if L>0, else OUT.
- LOAD_A: In_ready 1, Mux_in 0, Addr_in = k. Write_en = In_valid. k increments on each accepted beat. After beat L, go to LOAD_B with k = 1.
- LOAD_B: as LOAD_A with Addr_in = HALF+k. After beat L, go to ABS with k = 1.
- ABS: Opcode ABSDIFF, Addr_out1 k, Addr_out2 HALF+k, Addr_in HALF, Mux_in 1, Write_en 1. Next state: ACC.
- ACC: Opcode ADD, Addr_out1 0, Addr_out2 HALF, Addr_in 0, Mux_in 1, Write_en 1. k increments. Next state: ABS if k<L, else OUT.
- OUT: Addr_out1 0, Out_enable 1, Done 1. Next state: IDLE.
- The datapath has asynchronous read and synchronous write, so each ALU op completes in the same cycle.
- Start outside IDLE is ignored. Length and In_valid are don't-care outside their phases.
- In_valid low during LOAD: Write_en 0 and k holds; no timeout.

## Timing
- Start accepted at edge n → CLEAR in cycle n+1.
- Outputs decode combinationally from registered state and k. Write_en in LOAD also depends combinationally on In_valid.
- With no stalls, Done is seen at edge n+4L+2. Busy is high for 4L+2 cycles.
- Each stalled LOAD cycle adds exactly 1 cycle.
- RST_n low at any time: state IDLE, k = 0, L = 0, and all outputs 0 immediately. Register-file contents are not restored. After release, the next Start runs normally.

## Configuration
- DSEQ_ABORT_EN defined:
  - Adds input Abort (1 bit).
  - Abort=1 in any non-IDLE state → IDLE at the next edge. Done is not asserted and outputs go to 0.
  - Abort has priority over all transitions. A simultaneous Start in IDLE is ignored.
- DSEQ_ABORT_EN undefined: the port is absent and the FSM always completes.

## Structure
- Package dseq_pkg holds:
  - state enum
  - opcode constants OP_ADD/OP_SUB/OP_ABSDIFF/OP_PASS
  - ACC_ADDR = 0
- Sub-module dseq_decode: combinational decode of (state, k, In_valid) to datapath controls. The top module keeps the state register, k, L and the handshake logic.

## Test plan
- Reset: RST_n=0 mid-LOAD_A → all outputs 0 and Busy 0 in the same cycle; release, Start, L=2 → completes in 10 cycles.
- L=3, In_valid always 1, A=5,2,9 and B=1,7,9 → write addresses 1,2,3,9,10,11; ABS reads (1,9),(2,10),(3,11); Done at edge n+14; datapath output = 9.
- Same as above with In_valid low 2 cycles during LOAD_A → no writes in those cycles, k held, Done at edge n+16.
- Length=0 → CLEAR then OUT, Done at edge n+2, output 0. Length=12 → clamped to 7, Done at edge n+30.
- Start pulsed during ABS → ignored, single Done. Back-to-back Start in the cycle after Done → new run accepted.
- DSEQ_ABORT_EN: Abort during ACC → IDLE next cycle, no Done, Busy 0. Abort together with Start in IDLE → remains IDLE.
